// File: rtl/maze_pkg.sv
// Shared types, constants and map indexing for the maze game controller.
package maze_pkg;

    localparam int unsigned MAP_W    = 19;
    localparam int unsigned MAP_BITS = MAP_W * MAP_W;
    localparam int unsigned COORD_W  = 5;
    localparam int unsigned IDX_W    = 9;
    localparam int unsigned STEPS_W  = 10;

    localparam logic [STEPS_W-1:0] STEPS_MAX = STEPS_W'(999);
    localparam logic [COORD_W-1:0] START_X   = COORD_W'(1);
    localparam logic [COORD_W-1:0] START_Y   = COORD_W'(1);

    typedef enum logic [1:0] {
        MODE_WELCOME = 2'd0,
        MODE_CREATE  = 2'd1,
        MODE_PLAY    = 2'd2,
        MODE_WIN     = 2'd3
    } mode_e;

    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
    } pos_t;

    // Linear wall-map bit index; wraps modulo 2^IDX_W, so callers range-check first.
    function automatic logic [IDX_W-1:0] map_index(input logic [COORD_W-1:0] x,
                                                   input logic [COORD_W-1:0] y);
        return IDX_W'(IDX_W'(y) * IDX_W'(MAP_W) + IDX_W'(x));
    endfunction

endpackage

// File: rtl/move_timer.sv
// Loadable down-counter that rate-limits player moves; ready while the count is zero.
module move_timer #(
    parameter int unsigned TICKS = 50000000
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    output logic ready
);

    localparam int unsigned CNT_W = (TICKS > 1) ? $clog2(TICKS) : 1;
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(TICKS - 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = RELOAD;
        end else if (count_q != '0) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    // ready is registered alongside the count so it always reflects count_q == 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
            ready   <= 1'b1;
        end else begin
            count_q <= count_d;
            ready   <= (count_d == '0);
        end
    end

endmodule

// File: rtl/maze_game_ctrl.sv
// Maze game-flow controller: WELCOME/CREATE/PLAY/WIN sequencing, size selection,
// map regeneration requests and rate-limited, wall-checked player movement.
module maze_game_ctrl
    import maze_pkg::*;
#(
    parameter int unsigned MOVE_TICKS = 50000000,
    parameter int unsigned NUM_MIN    = 5,
    parameter int unsigned NUM_MAX    = 19
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                up,
    input  logic                down,
    input  logic                left,
    input  logic                right,
    input  logic                enter,
    input  logic [MAP_BITS-1:0] map,
    output logic [COORD_W-1:0]  num,
    output logic                regen,
    output logic [1:0]          mode,
    output logic [COORD_W-1:0]  my_x,
    output logic [COORD_W-1:0]  my_y,
    output logic                win,
    output logic [STEPS_W-1:0]  steps
);

    localparam logic [COORD_W-1:0] NUM_MIN_C = COORD_W'(NUM_MIN);
    localparam logic [COORD_W-1:0] NUM_MAX_C = COORD_W'(NUM_MAX);
    localparam logic [COORD_W-1:0] TWO       = COORD_W'(2);

    mode_e               state_q, state_d;
    logic [COORD_W-1:0]  num_q, num_d;
    pos_t                pos_q, pos_d;
    logic [STEPS_W-1:0]  steps_q, steps_d;
    logic                regen_q, regen_d;
    logic                win_q, win_d;

    logic                enter_q, up_q, down_q;
    logic                enter_edge, up_edge, down_edge;
    logic                dir_any;
    logic                timer_ready;
    logic                move;
    logic                start_play;

    pos_t                target;
    logic                target_in_range;
    logic [IDX_W-1:0]    target_idx;
    logic                target_wall;
    logic                target_ok;
    logic [COORD_W-1:0]  goal;

    assign enter_edge = enter & ~enter_q;
    assign up_edge    = up & ~up_q;
    assign down_edge  = down & ~down_q;
    assign dir_any    = up | down | left | right;
    assign goal       = num_q - TWO;

    // Candidate square for the highest-priority held direction, with bounds check.
    always_comb begin
        target          = pos_q;
        target_in_range = 1'b0;
        if (up) begin
            target.y        = pos_q.y - COORD_W'(1);
            target_in_range = (pos_q.y != '0);
        end else if (down) begin
            target.y        = pos_q.y + COORD_W'(1);
            target_in_range = (target.y < num_q);
        end else if (left) begin
            target.x        = pos_q.x - COORD_W'(1);
            target_in_range = (pos_q.x != '0);
        end else if (right) begin
            target.x        = pos_q.x + COORD_W'(1);
            target_in_range = (target.x < num_q);
        end
    end

    assign target_idx  = map_index(target.x, target.y);
    assign target_wall = (target_idx < IDX_W'(MAP_BITS)) ? map[target_idx] : 1'b1;
    assign target_ok   = target_in_range & ~target_wall;

    always_comb begin
        state_d    = state_q;
        num_d      = num_q;
        pos_d      = pos_q;
        steps_d    = steps_q;
        regen_d    = 1'b0;
        win_d      = win_q;
        move       = 1'b0;
        start_play = 1'b0;
        case (state_q)
            MODE_WELCOME: begin
                if (enter_edge) begin
                    state_d = MODE_CREATE;
                    regen_d = 1'b1;
                end else if (up_edge) begin
                    num_d = (num_q >= NUM_MAX_C - TWO) ? NUM_MAX_C : num_q + TWO;
                end else if (down_edge) begin
                    num_d = (num_q <= NUM_MIN_C + TWO) ? NUM_MIN_C : num_q - TWO;
                end
            end
            MODE_CREATE: begin
                if (enter_edge) begin
                    regen_d = 1'b1;
                end
                // The key that starts play only freezes the map; it is not a move.
                if (dir_any) begin
                    state_d    = MODE_PLAY;
                    pos_d      = '{x: START_X, y: START_Y};
                    steps_d    = '0;
                    start_play = 1'b1;
                end
            end
            MODE_PLAY: begin
                if (pos_q.x == goal && pos_q.y == goal) begin
                    state_d = MODE_WIN;
                    win_d   = 1'b1;
                end else if (timer_ready && dir_any && target_ok) begin
                    move    = 1'b1;
                    pos_d   = target;
                    steps_d = (steps_q == STEPS_MAX) ? steps_q : steps_q + STEPS_W'(1);
                end
            end
            MODE_WIN: begin
                if (enter_edge) begin
                    state_d = MODE_CREATE;
                    regen_d = 1'b1;
                    win_d   = 1'b0;
                end
            end
            default: state_d = MODE_WELCOME;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= MODE_WELCOME;
            num_q   <= NUM_MIN_C;
            pos_q   <= '{x: START_X, y: START_Y};
            steps_q <= '0;
            regen_q <= 1'b0;
            win_q   <= 1'b0;
            enter_q <= 1'b0;
            up_q    <= 1'b0;
            down_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            num_q   <= num_d;
            pos_q   <= pos_d;
            steps_q <= steps_d;
            regen_q <= regen_d;
            win_q   <= win_d;
            enter_q <= enter;
            up_q    <= up;
            down_q  <= down;
        end
    end

    // Starting a game clears the timer so the first move is not delayed.
    move_timer #(
        .TICKS (MOVE_TICKS)
    ) u_move_timer (
        .clk   (clk),
        .rst   (rst | start_play),
        .load  (move),
        .ready (timer_ready)
    );

    assign mode  = state_q;
    assign num   = num_q;
    assign regen = regen_q;
    assign my_x  = pos_q.x;
    assign my_y  = pos_q.y;
    assign win   = win_q;
    assign steps = steps_q;

endmodule

// File: tb/tb_maze_game_ctrl.sv
// Directed bench for maze_game_ctrl with a short move interval.
module tb_maze_game_ctrl;

    localparam int unsigned TB_TICKS = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         up, down, left, right, enter;
    logic [360:0] map_r;
    logic [4:0]   num;
    logic         regen;
    logic [1:0]   mode;
    logic [4:0]   my_x, my_y;
    logic         win;
    logic [9:0]   steps;

    int checks = 0;
    int errors = 0;
    int pulses;

    maze_game_ctrl #(
        .MOVE_TICKS (TB_TICKS),
        .NUM_MIN    (5),
        .NUM_MAX    (19)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .up    (up),
        .down  (down),
        .left  (left),
        .right (right),
        .enter (enter),
        .map   (map_r),
        .num   (num),
        .regen (regen),
        .mode  (mode),
        .my_x  (my_x),
        .my_y  (my_y),
        .win   (win),
        .steps (steps)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic open_cell(input int x, input int y);
        map_r[y * 19 + x] = 1'b0;
    endtask

    task automatic press_enter();
        enter = 1'b1;
        tick();
        enter = 1'b0;
        tick();
    endtask

    task automatic start_play();
        right = 1'b1;
        tick();
        right = 1'b0;
    endtask

    task automatic goal_map();
        map_r = '1;
        open_cell(1, 1); open_cell(2, 1); open_cell(3, 1);
        open_cell(3, 2); open_cell(3, 3);
    endtask

    initial begin
        rst = 1'b1; up = 1'b0; down = 1'b0; left = 1'b0; right = 1'b0; enter = 1'b0;
        map_r = '1;
        tick();
        tick();
        check("rst_mode", int'(mode), 0);
        check("rst_num", int'(num), 5);
        check("rst_regen", int'(regen), 0);
        check("rst_x", int'(my_x), 1);
        check("rst_y", int'(my_y), 1);
        check("rst_win", int'(win), 0);
        check("rst_steps", int'(steps), 0);
        rst = 1'b0;
        tick();

        // Size selection with saturation at both ends.
        for (int i = 0; i < 8; i++) begin
            up = 1'b1; tick(); up = 1'b0; tick();
        end
        check("num_sat_max", int'(num), 19);
        for (int i = 0; i < 10; i++) begin
            down = 1'b1; tick(); down = 1'b0; tick();
        end
        check("num_sat_min", int'(num), 5);

        // Held enter acts once.
        pulses = 0;
        enter = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            pulses += int'(regen);
        end
        enter = 1'b0;
        check("enter_once", pulses, 1);
        check("mode_create", int'(mode), 1);
        tick();
        check("regen_low", int'(regen), 0);

        // Enter in CREATE re-requests a map.
        enter = 1'b1;
        tick();
        check("create_regen", int'(regen), 1);
        check("create_stay", int'(mode), 1);
        enter = 1'b0;
        tick();
        check("create_regen_low", int'(regen), 0);

        // Open corridor on row 1, including one cell beyond num-1.
        map_r = '1;
        open_cell(1, 1); open_cell(2, 1); open_cell(3, 1); open_cell(4, 1); open_cell(5, 1);
        right = 1'b1;
        tick();
        check("play_mode", int'(mode), 2);
        check("play_x0", int'(my_x), 1);
        check("play_y0", int'(my_y), 1);
        check("play_steps0", int'(steps), 0);
        tick();
        check("mv1_x", int'(my_x), 2);
        repeat (3) tick();
        check("rate_hold_x", int'(my_x), 2);
        tick();
        check("mv2_x", int'(my_x), 3);
        repeat (4) tick();
        check("mv3_x", int'(my_x), 4);
        repeat (4) tick();
        check("range_x", int'(my_x), 4);
        check("corr_steps", int'(steps), 3);
        right = 1'b0;

        // Wall blocks, then down and priority.
        rst = 1'b1; tick(); rst = 1'b0;
        map_r = '1;
        open_cell(1, 1); open_cell(1, 2); open_cell(0, 2);
        press_enter();
        check("wall_create", int'(mode), 1);
        right = 1'b1;
        repeat (10) tick();
        right = 1'b0;
        check("wall_mode", int'(mode), 2);
        check("wall_x", int'(my_x), 1);
        check("wall_y", int'(my_y), 1);
        check("wall_steps", int'(steps), 0);
        down = 1'b1;
        tick();
        down = 1'b0;
        check("down_y", int'(my_y), 2);
        check("down_x", int'(my_x), 1);
        check("down_steps", int'(steps), 1);
        repeat (4) tick();
        up = 1'b1; left = 1'b1;
        tick();
        up = 1'b0; left = 1'b0;
        check("prio_x", int'(my_x), 1);
        check("prio_y", int'(my_y), 1);

        // Reset mid-play.
        rst = 1'b1; tick(); rst = 1'b0;
        goal_map();
        press_enter();
        start_play();
        right = 1'b1;
        repeat (5) tick();
        right = 1'b0;
        check("mid_x", int'(my_x), 3);
        check("mid_y", int'(my_y), 1);
        check("mid_steps", int'(steps), 2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_mode", int'(mode), 0);
        check("mid_rst_x", int'(my_x), 1);
        check("mid_rst_y", int'(my_y), 1);
        check("mid_rst_steps", int'(steps), 0);
        check("mid_rst_num", int'(num), 5);
        check("mid_rst_regen", int'(regen), 0);

        // Reach goal (3,3) on a 5x5 maze.
        press_enter();
        start_play();
        right = 1'b1;
        repeat (5) tick();
        right = 1'b0;
        repeat (4) tick();
        down = 1'b1;
        repeat (5) tick();
        down = 1'b0;
        check("goal_x", int'(my_x), 3);
        check("goal_y", int'(my_y), 3);
        check("goal_mode_play", int'(mode), 2);
        check("goal_win_low", int'(win), 0);
        tick();
        check("win_mode", int'(mode), 3);
        check("win_flag", int'(win), 1);
        check("win_steps", int'(steps), 4);
        enter = 1'b1;
        tick();
        enter = 1'b0;
        check("win_exit_mode", int'(mode), 1);
        check("win_exit_regen", int'(regen), 1);
        check("win_exit_win", int'(win), 0);
        tick();
        check("win_exit_regen_low", int'(regen), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
